// File: rtl/text_console_pkg.sv
// text_console_pkg: shared geometry, ASCII codes, writer states and cell address helper.
package text_console_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int ADDR_W = 12;
  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;
  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} wr_state_t;
  // row*80 as row*64 + row*16, so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
  endfunction
endpackage

// File: rtl/text_ram.sv
// text_ram: simple dual-port character RAM, sync write, registered read-before-write.
module text_ram
  import text_console_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [CELLS];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream console writer with cursor, clears and VGA glyph read port.
module text_console_writer
  import text_console_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iChar,
  input  logic       iValid,
  output logic       oReady,
  input  logic       iClear,
  input  logic [9:0] iDrawX,
  input  logic [9:0] iDrawY,
  output logic [9:0] oN,
  output logic [6:0] oCurX,
  output logic [4:0] oCurY
);
  wr_state_t state;
  logic [ADDR_W-1:0] ptr, waddr, raddr;
  logic [1:0] rsel;
  logic [7:0] rdata, wdata;
  logic [4:0] next_row;
  logic xfer, printable, bs_ok, adv, we, in_view;

  assign oReady = state == IDLE && !iClear;
  assign xfer = iValid && oReady;
  assign printable = iChar >= CH_PRINT_LO && iChar <= CH_PRINT_HI;
  assign bs_ok = iChar == CH_BS && oCurX != 7'd0;
  assign next_row = oCurY == 5'(ROWS - 1) ? 5'd0 : oCurY + 5'd1;
  assign adv = xfer && (iChar == CH_LF || (printable && oCurX == 7'(COLS - 1)));
  assign we = !iClear && (state != IDLE || (xfer && (printable || bs_ok)));
  assign waddr = state == CLR_ALL ? ptr :
                 state == CLR_ROW ? cell_addr(oCurY, ptr[6:0]) :
                 cell_addr(oCurY, printable ? oCurX : oCurX - 7'd1);
  assign wdata = state == IDLE && printable ? iChar : BLANK;
  assign in_view = iDrawX < 10'(COLS * 8) && iDrawY < 10'(ROWS * 16);
  assign raddr = in_view ? cell_addr(iDrawY[8:4], iDrawX[9:3]) : '0;
  // rsel tracks the read issued last cycle: 0 = reset, 1 = off-screen, 2 = RAM data
  assign oN = rsel == 2'd2 ? {2'b00, rdata} : rsel == 2'd1 ? {2'b00, BLANK} : 10'd0;

  text_ram u_ram (
    .clk   (iCLK),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= CLR_ALL;
      ptr <= '0;
      oCurX <= '0;
      oCurY <= '0;
      rsel <= 2'd0;
    end else begin
      rsel <= in_view ? 2'd2 : 2'd1;
      if (iClear) begin
        state <= CLR_ALL;
        ptr <= '0;
        oCurX <= '0;
        oCurY <= '0;
      end else begin
        case (state)
          CLR_ALL: begin
            ptr <= ptr + 1'b1;
            if (ptr == ADDR_W'(CELLS - 1)) state <= IDLE;
          end
          CLR_ROW: begin
            ptr <= ptr + 1'b1;
            if (ptr[6:0] == 7'(COLS - 1)) state <= IDLE;
          end
          default: begin
            if (adv) begin
              oCurX <= '0;
              oCurY <= next_row;
              ptr <= '0;
              state <= CLR_ROW;
            end else if (xfer && printable) oCurX <= oCurX + 7'd1;
            else if (xfer && iChar == CH_CR) oCurX <= '0;
            else if (xfer && bs_ok) oCurX <= oCurX - 7'd1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: scoreboard bench with a screen/cursor model of the console writer.
`timescale 1ns/1ps
module tb_text_console_writer;
  logic iCLK = 0, iRST_N = 0, iValid = 0, iClear = 0, oReady;
  logic [7:0] iChar = 0;
  logic [9:0] iDrawX = 0, iDrawY = 0, oN;
  logic [6:0] oCurX;
  logic [4:0] oCurY;
  int n_cmp = 0, n_err = 0;
  logic [7:0] scr [2400];
  int mx = 0, my = 0;
  logic [9:0] exp_q [$];

  text_console_writer dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iChar(iChar), .iValid(iValid), .oReady(oReady),
    .iClear(iClear), .iDrawX(iDrawX), .iDrawY(iDrawY), .oN(oN), .oCurX(oCurX), .oCurY(oCurY)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic blank_all();
    for (int i = 0; i < 2400; i++) scr[i] = 8'h20;
  endtask

  task automatic model_adv();
    mx = 0;
    my = (my == 29) ? 0 : my + 1;
    for (int i = 0; i < 80; i++) scr[my*80+i] = 8'h20;
  endtask

  task automatic model(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[my*80+mx] = c;
      if (mx == 79) model_adv(); else mx++;
    end else if (c == 8'h0A) model_adv();
    else if (c == 8'h0D) mx = 0;
    else if (c == 8'h08 && mx > 0) begin
      mx--;
      scr[my*80+mx] = 8'h20;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    iChar = c;
    iValid = 1;
    while (!oReady && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= 3000) chk("ready_timeout", 0, 1);
    @(negedge iCLK);
    iValid = 0;
    model(c);
  endtask

  task automatic cnt_low(output int n);
    n = 0;
    while (!oReady && n < 3000) begin
      n++;
      @(negedge iCLK);
    end
  endtask

  task automatic rd(input int x, input int y);
    iDrawX = 10'(x);
    iDrawY = 10'(y);
    exp_q.push_back((x < 640 && y < 480) ? {2'b00, scr[(y/16)*80 + x/8]} : 10'h020);
    @(negedge iCLK);
    chk($sformatf("oN(%0d,%0d)", x, y), oN, exp_q.pop_front());
  endtask

  initial begin
    int n;
    repeat (3) @(negedge iCLK);
    chk("rst_ready", oReady, 0);
    chk("rst_oN", oN, 0);
    chk("rst_curx", oCurX, 0);
    chk("rst_cury", oCurY, 0);
    iRST_N = 1;
    cnt_low(n);
    chk("init_clear_len", n, 2400);
    blank_all();
    rd(0, 0);
    rd(639, 479);
    rd(640, 0);
    // back-to-back "HI"
    send(8'h48);
    chk("hi_curx1", oCurX, 1);
    send(8'h49);
    chk("hi_curx2", oCurX, 2);
    rd(8, 0);
    rd(0, 0);
    // wrap from column 79 of row 5
    send(8'h0A);
    send(8'h5A);
    repeat (4) send(8'h0A);
    repeat (79) send(8'h2E);
    chk("pre_wrap_curx", oCurX, 79);
    chk("pre_wrap_cury", oCurY, 5);
    send(8'h41);
    cnt_low(n);
    chk("row_clear_len", n, 80);
    chk("wrap_curx", oCurX, 0);
    chk("wrap_cury", oCurY, 6);
    rd(79*8, 5*16);
    rd(78*8, 5*16 + 7);
    for (int i = 0; i < 80; i += 13) rd(i*8, 6*16 + 3);
    // LF from the last row wraps to row 0 and blanks it
    while (my != 29) send(8'h0A);
    chk("last_row", oCurY, 29);
    send(8'h0A);
    chk("lf_wrap_curx", oCurX, 0);
    chk("lf_wrap_cury", oCurY, 0);
    cnt_low(n);
    chk("row0_clear_len", n, 80);
    rd(0, 0);
    rd(8, 0);
    rd(0, 16);
    // backspace
    send(8'h0A);
    send(8'h0A);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    chk("bs_pre_curx", oCurX, 3);
    send(8'h08);
    chk("bs_curx", oCurX, 2);
    chk("bs_cury", oCurY, 2);
    rd(16, 32);
    rd(8, 32);
    send(8'h0D);
    send(8'h08);
    chk("bs0_curx", oCurX, 0);
    chk("bs0_cury", oCurY, 2);
    send(8'h07);
    chk("drop_curx", oCurX, 0);
    // clear beats a same-cycle transfer
    iDrawX = 10'd700;
    iChar = 8'h58;
    iValid = 1;
    iClear = 1;
    #1 chk("clr_ready", oReady, 0);
    @(negedge iCLK);
    iClear = 0;
    iValid = 0;
    blank_all();
    mx = 0;
    my = 0;
    chk("clr_curx", oCurX, 0);
    chk("clr_cury", oCurY, 0);
    chk("clr_busy", oReady, 0);
    repeat (100) @(negedge iCLK);
    chk("offscreen_oN", oN, 10'h020);
    #2 iRST_N = 0;
    #1 chk("async_oN", oN, 0);
    chk("async_ready", oReady, 0);
    chk("async_curx", oCurX, 0);
    @(negedge iCLK);
    iRST_N = 1;
    cnt_low(n);
    chk("reclear_len", n, 2400);
    rd(8, 0);
    rd(16, 32);
    rd(639, 479);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
